// File: rtl/text_line_ctrl.sv
// Character store and controller for one on-screen text line: takes message/score
// requests, composes the line into a shadow bank and swaps banks on vertical blank.
module text_line_ctrl #(
  parameter int WIDTH        = 32,
  parameter int BLINK_FRAMES = 30,
  parameter int SHOW_FRAMES  = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_msg,
  input  logic [13:0] req_score,
  input  logic        req_blink,
  input  logic        vblnk,
  input  logic [7:0]  char_xy,
  output logic [6:0]  char_code,
  output logic        enable,
  output logic        busy
);

  localparam int AW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int MAXF = (BLINK_FRAMES > SHOW_FRAMES) ? BLINK_FRAMES : SHOW_FRAMES;
  localparam int FW   = (MAXF > 0) ? $clog2(MAXF + 1) : 1;
  localparam int BW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [AW-1:0] COL_LAST   = AW'(WIDTH - 1);
  localparam logic [8:0]    WIDTH_L    = 9'(WIDTH);
  localparam logic [FW-1:0] FRAME_MAX  = FW'(MAXF);
  localparam logic [FW-1:0] SHOW_L     = FW'(SHOW_FRAMES);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  typedef enum logic [2:0] {IDLE, CONVERT, FILL, WAIT_VB, SWAP} state_t;
  state_t state, state_nx;

  logic [6:0]    bank [2][WIDTH];
  logic          disp_sel;
  logic [2:0]    msg_q, disp_msg;
  logic          blink_q, disp_blink;
  logic [13:0]   bin;
  logic [15:0]   bcd, bcd_adj;
  logic [3:0]    step;
  logic [AW-1:0] col;
  logic          vblnk_d, vb_rise;
  logic [FW-1:0] frame_cnt, frame_nx;
  logic [BW-1:0] blink_cnt;
  logic          blink_wrap, show_hit;
  logic [6:0]    fill_char;

  function automatic logic [6:0] digit(input logic [3:0] d);
    return 7'h30 + {3'b000, d};
  endfunction

  function automatic logic [6:0] msg_char(input logic [2:0] m, input logic [AW-1:0] c,
                                          input logic [15:0] d);
    logic [7:0] c8;
    logic [6:0] ch;
    c8 = 8'(c);
    ch = 7'h20;
    case (m)
      3'd1: case (c8)
        8'd0: ch = 7'h53;  8'd1: ch = 7'h43;  8'd2: ch = 7'h4F;
        8'd3: ch = 7'h52;  8'd4: ch = 7'h45;
        8'd6: ch = digit(d[15:12]);  8'd7: ch = digit(d[11:8]);
        8'd8: ch = digit(d[7:4]);    8'd9: ch = digit(d[3:0]);
        default: ch = 7'h20;
      endcase
      3'd2: case (c8)
        8'd0: ch = 7'h52;  8'd1: ch = 7'h4F;  8'd2: ch = 7'h55;
        8'd3: ch = 7'h4E;  8'd4: ch = 7'h44;
        8'd6: ch = digit(d[7:4]);    8'd7: ch = digit(d[3:0]);
        default: ch = 7'h20;
      endcase
      3'd3: case (c8)
        8'd0: ch = 7'h47;  8'd1: ch = 7'h41;  8'd2: ch = 7'h4D;
        8'd3: ch = 7'h45;  8'd5: ch = 7'h4F;  8'd6: ch = 7'h56;
        8'd7: ch = 7'h45;  8'd8: ch = 7'h52;
        default: ch = 7'h20;
      endcase
      3'd4: case (c8)
        8'd0: ch = 7'h50;  8'd1: ch = 7'h45;  8'd2: ch = 7'h52;
        8'd3: ch = 7'h46;  8'd4: ch = 7'h45;  8'd5: ch = 7'h43;
        8'd6: ch = 7'h54;  8'd7: ch = 7'h21;
        default: ch = 7'h20;
      endcase
      default: ch = 7'h20;
    endcase
    return ch;
  endfunction

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign vb_rise   = vblnk && !vblnk_d;

  always_comb begin
    bcd_adj = bcd;
    for (int unsigned i = 0; i < 4; i++)
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    frame_nx   = (frame_cnt == FRAME_MAX) ? frame_cnt : frame_cnt + 1'b1;
    blink_wrap = (blink_cnt == BLINK_LAST);
    show_hit   = (SHOW_FRAMES != 0) && (frame_nx >= SHOW_L);
    fill_char  = msg_char(msg_q, col, bcd);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_valid) state_nx = CONVERT;
      CONVERT: if (step == 4'd13) state_nx = FILL;
      FILL:    if (col == COL_LAST) state_nx = WAIT_VB;
      WAIT_VB: if (vb_rise) state_nx = SWAP;
      SWAP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        bank[0][i] <= 7'h20;
        bank[1][i] <= 7'h20;
      end
      disp_sel   <= 1'b0;
      msg_q      <= '0;
      blink_q    <= 1'b0;
      disp_msg   <= '0;
      disp_blink <= 1'b0;
      bin        <= '0;
      bcd        <= '0;
      step       <= '0;
      col        <= '0;
      vblnk_d    <= 1'b0;
      frame_cnt  <= '0;
      blink_cnt  <= '0;
      enable     <= 1'b0;
      char_code  <= 7'h20;
    end else begin
      vblnk_d <= vblnk;
      if ({1'b0, char_xy} < WIDTH_L) char_code <= bank[disp_sel][char_xy[AW-1:0]];
      else                           char_code <= 7'h20;

      if (state == IDLE && req_valid) begin
        msg_q   <= req_msg;
        blink_q <= req_blink;
        bin     <= (req_score > 14'd9999) ? 14'd9999 : req_score;
        bcd     <= '0;
        step    <= '0;
      end

      if (state == CONVERT) begin
        bcd  <= {bcd_adj[14:0], bin[13]};
        bin  <= {bin[12:0], 1'b0};
        step <= step + 4'd1;
      end

      if (state == FILL) begin
        bank[~disp_sel][col] <= fill_char;
        col <= (col == COL_LAST) ? '0 : col + 1'b1;
      end

      // Timeout is tracked by a saturating count; blink phase uses its own modulo count.
      if (state == SWAP) begin
        disp_sel   <= ~disp_sel;
        disp_msg   <= msg_q;
        disp_blink <= blink_q;
        frame_cnt  <= '0;
        blink_cnt  <= '0;
        enable     <= (msg_q != 3'd0);
      end else if (vb_rise && state != WAIT_VB) begin
        frame_cnt <= frame_nx;
        blink_cnt <= blink_wrap ? '0 : blink_cnt + 1'b1;
        if (disp_msg == 3'd0 || show_hit) enable <= 1'b0;
        else if (disp_blink && blink_wrap) enable <= ~enable;
      end
    end
  end

endmodule
